// File: rtl/vip_conv2d_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vip_conv2d_pkg
// Description : Shared types and default sizing for the conv2d filter
//               scheduler and its gather stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vip_conv2d_pkg;

  // Default sizing: 32-bit words, four output channels, 112x112 frame
  localparam int C_DWIDTH = 32;
  localparam int C_NFILT  = 4;
  localparam int C_NPIX   = 12544;
  localparam int C_NOUT   = 12544;

  // Frame-level scheduler states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vip_conv2d_gather.sv
`default_nettype none
// ============================================================================
// Module      : vip_conv2d_gather
// Description : Round-robin collector. Pops filter output FIFOs in strict
//               channel order into a single registered output word with a
//               valid/ready handshake, counting words per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_conv2d_gather
  import vip_conv2d_pkg::*;
#(
  parameter int DWIDTH = C_DWIDTH,
  parameter int NFILT  = C_NFILT,
  parameter int NOUT   = C_NOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic [DWIDTH*NFILT-1:0] i_out_data,
  input  logic [NFILT-1:0]        i_out_empty,
  output logic [NFILT-1:0]        o_out_rdreq,
  output logic [DWIDTH-1:0]       o_dst_data,
  output logic                    o_dst_valid,
  input  logic                    i_dst_ready,
  output logic                    o_drain_ok
);

  localparam int GPW   = (NFILT > 1) ? $clog2(NFILT) : 1;
  localparam int TOTAL = NOUT * NFILT;
  localparam int OCW   = $clog2(TOTAL + 1);

  localparam logic [GPW-1:0] c_GP_LAST   = GPW'(NFILT - 1);
  localparam logic [OCW-1:0] c_OUT_TOTAL = OCW'(TOTAL);

  logic [GPW-1:0]    r_gp;
  logic [OCW-1:0]    r_out_cnt;
  logic [DWIDTH-1:0] r_dst_data;
  logic              r_dst_valid;

  logic [DWIDTH-1:0] w_head;
  logic              w_gp_empty;
  logic              w_room;
  logic              w_all_out;
  logic              w_pop;

  // Select the head word and empty flag of the channel the pointer names
  always_comb begin
    w_head     = '0;
    w_gp_empty = 1'b1;
    for (int k = 0; k < NFILT; k++) begin
      if (r_gp == GPW'(k)) begin
        w_head     = i_out_data[k*DWIDTH +: DWIDTH];
        w_gp_empty = i_out_empty[k];
      end
    end
  end

  // Pop only the pointed-to channel; an empty channel stalls the whole ring
  always_comb begin
    w_room      = ~r_dst_valid | i_dst_ready;
    w_all_out   = (r_out_cnt == c_OUT_TOTAL);
    w_pop       = i_en & ~w_gp_empty & w_room & ~w_all_out;
    o_drain_ok  = w_all_out & w_room;
    o_out_rdreq = '0;
    for (int k = 0; k < NFILT; k++) begin
      o_out_rdreq[k] = w_pop & (r_gp == GPW'(k));
    end
  end

  // Pointer, frame word count and output register; accept+pop keeps valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gp        <= '0;
      r_out_cnt   <= '0;
      r_dst_data  <= '0;
      r_dst_valid <= 1'b0;
    end else begin
      if (i_clr) begin
        r_gp      <= '0;
        r_out_cnt <= '0;
      end else if (w_pop) begin
        r_gp      <= (r_gp == c_GP_LAST) ? '0 : r_gp + 1'b1;
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      if (w_pop) begin
        r_dst_data  <= w_head;
        r_dst_valid <= 1'b1;
      end else if (r_dst_valid & i_dst_ready) begin
        r_dst_valid <= 1'b0;
      end
    end
  end

  assign o_dst_data  = r_dst_data;
  assign o_dst_valid = r_dst_valid;

endmodule
`default_nettype wire

// File: rtl/vip_conv2d_filter_sched.sv
`default_nettype none
// ============================================================================
// Module      : vip_conv2d_filter_sched
// Description : Frame scheduler for a bank of conv2d filters. Broadcasts
//               source words to every filter in lock-step and gathers the
//               results round-robin into one channel-interleaved stream.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_conv2d_filter_sched
  import vip_conv2d_pkg::*;
#(
  parameter int DWIDTH = C_DWIDTH,
  parameter int NFILT  = C_NFILT,
  parameter int NPIX   = C_NPIX,
  parameter int NOUT   = C_NOUT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [DWIDTH*3-1:0]     src_data,
  input  logic                    src_empty,
  output logic                    src_rdreq,
  output logic [DWIDTH*3-1:0]     flt_in_data,
  output logic [NFILT-1:0]        flt_in_wrreq,
  input  logic [NFILT-1:0]        flt_in_full,
  input  logic [DWIDTH*NFILT-1:0] flt_out_data,
  input  logic [NFILT-1:0]        flt_out_empty,
  output logic [NFILT-1:0]        flt_out_rdreq,
  output logic [DWIDTH-1:0]       dst_data,
  output logic                    dst_valid,
  input  logic                    dst_ready
);

  localparam int INW = $clog2(NPIX + 1);
  localparam logic [INW-1:0] c_NPIX = INW'(NPIX);

  sched_state_t   r_state;
  sched_state_t   w_state_nxt;
  logic [INW-1:0] r_in_cnt;
  logic           w_bcast;
  logic           w_clr;
  logic           w_gather_en;
  logic           w_drain_ok;

  // Broadcast fires only when every filter can take the word
  always_comb begin
    w_bcast = (r_state == RUN) & ~src_empty & ~|flt_in_full & (r_in_cnt != c_NPIX);
  end

  assign src_rdreq    = w_bcast;
  assign flt_in_wrreq = {NFILT{w_bcast}};
  assign flt_in_data  = src_data;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; counters clear on leaving IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    w_gather_en = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = RUN;
          w_clr       = 1'b1;
        end
      end
      RUN: begin
        w_gather_en = 1'b1;
        if (r_in_cnt == c_NPIX) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_gather_en = 1'b1;
        if (w_drain_ok) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Input word counter for the current frame
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_cnt <= '0;
    end else if (w_clr) begin
      r_in_cnt <= '0;
    end else if (w_bcast) begin
      r_in_cnt <= r_in_cnt + 1'b1;
    end
  end

  vip_conv2d_gather #(
    .DWIDTH (DWIDTH),
    .NFILT  (NFILT),
    .NOUT   (NOUT)
  ) u_gather (
    .clk         (clock),
    .rst         (reset),
    .i_en        (w_gather_en),
    .i_clr       (w_clr),
    .i_out_data  (flt_out_data),
    .i_out_empty (flt_out_empty),
    .o_out_rdreq (flt_out_rdreq),
    .o_dst_data  (dst_data),
    .o_dst_valid (dst_valid),
    .i_dst_ready (dst_ready),
    .o_drain_ok  (w_drain_ok)
  );

endmodule
`default_nettype wire
